// File: rtl/pq_sequencer_if.sv
// Command/response handshake and single-port BRAM bus for the QuickQ sequencer.
// slave: sequencer side, master: command source, mem: BRAM side.
interface pq_sequencer_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8
);
  logic              cmd_valid;
  logic              cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic              cmd_ready;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;
  logic              bram_en;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wdata;
  logic [DATA_W-1:0] bram_rdata;

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, bram_rdata,
    output cmd_ready, resp_valid, resp_data, resp_err,
           bram_en, bram_we, bram_addr, bram_wdata
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, resp_valid, resp_data, resp_err
  );

  modport mem (
    input  bram_en, bram_we, bram_addr, bram_wdata,
    output bram_rdata
  );
endinterface

// File: rtl/pq_sequencer.sv
// QuickQ priority-queue sequencer: walks a sorted BRAM array slot by slot,
// inserting with compare/swap on enqueue and shifting down on dequeue.
module pq_sequencer #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  pq_sequencer_if.slave bus,
  output logic [7:0]   count,
  output logic         full,
  output logic         empty
);
  localparam int unsigned       CNT_W    = 8;
  localparam logic [DATA_W-1:0] SENTINEL = '1;
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_ENQ_RD, S_ENQ_CMP, S_DEQ_HEAD,
    S_DEQ_CAP, S_DEQ_RD, S_DEQ_WR, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] carry_q, carry_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic              full_q, empty_q, cmd_ready_q;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;

  logic              bram_en_c, bram_we_c;
  logic [CNT_W-1:0]  bram_addr_c;
  logic [DATA_W-1:0] bram_wdata_c;
  logic [CNT_W-1:0]  nxt_idx_c;

  // Next state, datapath updates and the BRAM access for the current cycle.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    count_d      = count_q;
    carry_d      = carry_q;
    head_d       = head_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_data_d  = '0;
    bram_en_c    = 1'b0;
    bram_we_c    = 1'b0;
    bram_addr_c  = '0;
    bram_wdata_c = '0;
    nxt_idx_c    = idx_q + CNT_W'(1);

    unique case (state_q)
      S_INIT: begin
        bram_en_c    = 1'b1;
        bram_we_c    = 1'b1;
        bram_addr_c  = idx_q;
        bram_wdata_c = SENTINEL;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = S_IDLE;
        end else begin
          idx_d = nxt_idx_c;
        end
      end
      S_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          idx_d = '0;
          if ((!bus.cmd_op && full_q) || (bus.cmd_op && empty_q)) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            state_d      = S_DONE;
          end else if (!bus.cmd_op) begin
            carry_d = bus.cmd_data;
            state_d = S_ENQ_RD;
          end else begin
            state_d = S_DEQ_HEAD;
          end
        end
      end
      S_ENQ_RD: begin
        bram_en_c   = 1'b1;
        bram_addr_c = idx_q;
        state_d     = S_ENQ_CMP;
      end
      S_ENQ_CMP: begin
        // Strict compare keeps a new value behind existing equal values.
        if (carry_q < bus.bram_rdata) begin
          bram_en_c    = 1'b1;
          bram_we_c    = 1'b1;
          bram_addr_c  = idx_q;
          bram_wdata_c = carry_q;
          carry_d      = bus.bram_rdata;
        end
        if (idx_q == count_q) begin
          count_d      = count_q + CNT_W'(1);
          resp_valid_d = 1'b1;
          state_d      = S_DONE;
        end else begin
          idx_d   = nxt_idx_c;
          state_d = S_ENQ_RD;
        end
      end
      S_DEQ_HEAD: begin
        bram_en_c   = 1'b1;
        bram_addr_c = '0;
        state_d     = S_DEQ_CAP;
      end
      S_DEQ_CAP: begin
        head_d  = bus.bram_rdata;
        idx_d   = '0;
        state_d = S_DEQ_RD;
      end
      S_DEQ_RD: begin
        if (nxt_idx_c != DEPTH_C) begin
          bram_en_c   = 1'b1;
          bram_addr_c = nxt_idx_c;
        end
        state_d = S_DEQ_WR;
      end
      S_DEQ_WR: begin
        // Past the last slot there is nothing to read; shift in the sentinel.
        bram_en_c    = 1'b1;
        bram_we_c    = 1'b1;
        bram_addr_c  = idx_q;
        bram_wdata_c = (nxt_idx_c == DEPTH_C) ? SENTINEL : bus.bram_rdata;
        idx_d        = nxt_idx_c;
        if (nxt_idx_c == count_q) begin
          count_d      = count_q - CNT_W'(1);
          resp_valid_d = 1'b1;
          resp_data_d  = head_q;
          state_d      = S_DONE;
        end else begin
          state_d = S_DEQ_RD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_INIT;
      end
    endcase

    if (rst) begin
      bram_en_c = 1'b0;
      bram_we_c = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_INIT;
      idx_q        <= '0;
      count_q      <= '0;
      carry_q      <= '0;
      head_q       <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      cmd_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      count_q      <= count_d;
      carry_q      <= carry_d;
      head_q       <= head_d;
      full_q       <= (count_d == DEPTH_C);
      empty_q      <= (count_d == '0);
      cmd_ready_q  <= (state_d == S_IDLE);
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.bram_en    = bram_en_c;
  assign bus.bram_we    = bram_we_c;
  assign bus.bram_addr  = ADDR_W'(bram_addr_c);
  assign bus.bram_wdata = bram_wdata_c;
  assign count          = count_q;
  assign full           = full_q;
  assign empty          = empty_q;
endmodule

// File: tb/tb_pq_sequencer.sv
// Bench for pq_sequencer (DEPTH=5): directed table, mid-command reset and
// random commands checked against a sorted-queue reference model.
module tb_pq_sequencer;
  localparam int unsigned DEPTH  = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned LOG_N  = 4096;
  localparam logic [31:0] SENT   = 32'hFFFF_FFFF;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] count;
  logic       full, empty;

  pq_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  pq_sequencer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  // BRAM model with a write log.
  logic [31:0] mem [DEPTH];
  logic [7:0]  log_addr [LOG_N];
  logic [31:0] log_data [LOG_N];
  int          n_writes = 0;
  int          n_oob    = 0;

  initial bus.bram_rdata = '0;

  always @(posedge clk) begin
    if (bus.bram_en) begin
      if (bus.bram_addr >= ADDR_W'(DEPTH)) begin
        n_oob <= n_oob + 1;
      end else if (bus.bram_we) begin
        mem[bus.bram_addr]             <= bus.bram_wdata;
        log_addr[n_writes % LOG_N]     <= bus.bram_addr;
        log_data[n_writes % LOG_N]     <= bus.bram_wdata;
        n_writes                       <= n_writes + 1;
      end else begin
        bus.bram_rdata <= mem[bus.bram_addr];
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] ref_q [$];

  typedef struct {
    logic        op;
    logic [31:0] data;
    logic        exp_err;
    logic [31:0] exp_data;
    int          exp_count;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_mem(input string tag, input logic [31:0] exp [DEPTH]);
    for (int k = 0; k < DEPTH; k++) chk($sformatf("%s.slot%0d", tag, k), mem[k], exp[k]);
  endtask

  task automatic model_snapshot(output logic [31:0] snap [DEPTH]);
    for (int k = 0; k < DEPTH; k++) snap[k] = (k < ref_q.size()) ? ref_q[k] : SENT;
  endtask

  // Reset for the given cycles, then check the INIT sweep.
  task automatic do_reset(input int cycles);
    int guard;
    int base;
    bus.cmd_valid = 1'b0;
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    chk("rst.cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst.resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst.resp_data", bus.resp_data, 32'd0);
    chk("rst.bram_en", 32'(bus.bram_en), 32'd0);
    chk("rst.bram_we", 32'(bus.bram_we), 32'd0);
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.empty", 32'(empty), 32'd1);
    chk("rst.full", 32'(full), 32'd0);
    base = n_writes;
    rst = 1'b0;
    guard = 0;
    while (bus.cmd_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("init.ready", 32'(bus.cmd_ready), 32'd1);
    chk("init.nwrites", 32'(n_writes - base), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("init.addr%0d", i), 32'(log_addr[(base + i) % LOG_N]), 32'(i));
      chk($sformatf("init.data%0d", i), log_data[(base + i) % LOG_N], SENT);
    end
    chk("init.count", 32'(count), 32'd0);
    chk("init.empty", 32'(empty), 32'd1);
  endtask

  // Issue one command; junk is held on the command bus while busy and must be ignored.
  task automatic run_cmd(input logic op, input logic [31:0] data,
                         output logic [31:0] rd, output logic rerr,
                         output int lat, output int nwr, output logic [9:0] flags);
    int guard;
    int wr0;
    guard = 0;
    while (bus.cmd_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("cmd.ready", 32'(bus.cmd_ready), 32'd1);
    wr0 = n_writes;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    @(negedge clk);
    chk("cmd.ready_drop", 32'(bus.cmd_ready), 32'd0);
    bus.cmd_op   = ~op;
    bus.cmd_data = $urandom;
    lat = 0;
    while (bus.resp_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    bus.cmd_valid = 1'b0;
    chk("cmd.resp_seen", 32'(bus.resp_valid), 32'd1);
    rd    = bus.resp_data;
    rerr  = bus.resp_err;
    flags = {full, empty, count};
    nwr   = n_writes - wr0;
    @(negedge clk);
    chk("cmd.resp_pulse", 32'(bus.resp_valid), 32'd0);
  endtask

  task automatic apply(input string tag, input logic op, input logic [31:0] data,
                       input logic exp_err, input logic [31:0] exp_data,
                       input int cnt_before, input int exp_cnt);
    logic [31:0] rd;
    logic        rerr;
    logic [9:0]  flags;
    int          lat, nwr, exp_lat;
    run_cmd(op, data, rd, rerr, lat, nwr, flags);
    exp_lat = exp_err ? 0 : (op ? 2 + 2 * cnt_before : 2 * (cnt_before + 1));
    chk({tag, ".err"}, 32'(rerr), 32'(exp_err));
    chk({tag, ".data"}, rd, exp_data);
    chk({tag, ".count"}, 32'(flags[7:0]), 32'(exp_cnt));
    chk({tag, ".full"}, 32'(flags[9]), 32'(exp_cnt == DEPTH));
    chk({tag, ".empty"}, 32'(flags[8]), 32'(exp_cnt == 0));
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    if (exp_err) chk({tag, ".nwrites"}, 32'(nwr), 32'd0);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      apply($sformatf("vec%0d", i), vecs[i].op, vecs[i].data, vecs[i].exp_err,
            vecs[i].exp_data, (i == 0) ? 0 : vecs[i-1].exp_count, vecs[i].exp_count);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] snap [DEPTH];
    int          seen;
    logic        op, exp_err;
    logic [31:0] d, exp_data;
    int          r, cnt_before, pos;

    vecs[0]  = '{1'b0, 32'd2,          1'b0, 32'd0, 1};
    vecs[1]  = '{1'b0, 32'd1,          1'b0, 32'd0, 2};
    vecs[2]  = '{1'b1, 32'd0,          1'b0, 32'd1, 1};
    vecs[3]  = '{1'b1, 32'd0,          1'b0, 32'd2, 0};
    vecs[4]  = '{1'b1, 32'd0,          1'b1, 32'd0, 0};
    vecs[5]  = '{1'b0, 32'd7,          1'b0, 32'd0, 1};
    vecs[6]  = '{1'b0, 32'd3,          1'b0, 32'd0, 2};
    vecs[7]  = '{1'b0, 32'd9,          1'b0, 32'd0, 3};
    vecs[8]  = '{1'b0, 32'd3,          1'b0, 32'd0, 4};
    vecs[9]  = '{1'b1, 32'd0,          1'b0, 32'd3, 3};
    vecs[10] = '{1'b0, 32'd5,          1'b0, 32'd0, 4};
    vecs[11] = '{1'b0, 32'hF657_C062,  1'b0, 32'd0, 5};
    vecs[12] = '{1'b0, 32'hF680_D628,  1'b1, 32'd0, 5};
    vecs[13] = '{1'b1, 32'd0,          1'b0, 32'd3, 4};
    vecs[14] = '{1'b1, 32'd0,          1'b0, 32'd5, 3};

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 1'b0;
    bus.cmd_data  = '0;
    rst           = 1'b1;
    @(negedge clk);
    do_reset(3);

    run_rows(0, 1);
    snap = '{32'd1, 32'd2, SENT, SENT, SENT};
    chk_mem("snap_a", snap);
    run_rows(2, 8);
    snap = '{32'd3, 32'd3, 32'd7, 32'd9, SENT};
    chk_mem("snap_b", snap);
    run_rows(9, 9);
    snap = '{32'd3, 32'd7, 32'd9, SENT, SENT};
    chk_mem("snap_c", snap);
    run_rows(10, 14);
    snap = '{32'd7, 32'd9, 32'hF657_C062, SENT, SENT};
    chk_mem("snap_d", snap);

    // Reset in the middle of an enqueue walk with count=3.
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 1'b0;
    bus.cmd_data  = 32'd4;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    seen = 0;
    repeat (4) begin
      if (bus.resp_valid === 1'b1) seen++;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    if (bus.resp_valid === 1'b1) seen++;
    do_reset(1);
    chk("abort.no_resp", 32'(seen), 32'd0);
    apply("abort.deq", 1'b1, 32'd0, 1'b1, 32'd0, 0, 0);
    ref_q.delete();

    // Random commands against the sorted-queue model.
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6)       d = 32'($urandom_range(0, 7));
      else if (r == 6) d = SENT;
      else             d = $urandom;
      op         = 1'($urandom_range(0, 1));
      cnt_before = ref_q.size();
      exp_data   = '0;
      if (!op) begin
        exp_err = (cnt_before == DEPTH);
        if (!exp_err) begin
          pos = 0;
          while (pos < ref_q.size() && ref_q[pos] <= d) pos++;
          ref_q.insert(pos, d);
        end
      end else begin
        exp_err = (cnt_before == 0);
        if (!exp_err) exp_data = ref_q.pop_front();
      end
      apply($sformatf("rnd%0d", n), op, d, exp_err, exp_data, cnt_before, ref_q.size());
      model_snapshot(snap);
      chk_mem($sformatf("rnd%0d.mem", n), snap);
    end

    chk("bram.out_of_range", 32'(n_oob), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
